gray_bcd_converter: RTL
=======================

GRAY_BCD_CONVERTER -- requirements
Module: gray_bcd_converter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, giving the input code width; supported range 4..8.
REQ-002 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous and active-low.
REQ-004 SHALL have port start  input  1  request conversion of code_in; sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  0 = code_in is plain binary, 1 = code_in is Gray code; sampled with start.
REQ-006 SHALL have port code_in  input  WIDTH  value to convert; sampled with start.
REQ-007 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-008 SHALL have port valid  output  1  one-cycle pulse marking new result on digit outputs.
REQ-009 SHALL have port bcd_units  output  4  units decimal digit, 0..9.
REQ-010 SHALL have port bcd_tens  output  4  tens decimal digit, 0..9.
REQ-011 SHALL have port bcd_hundreds  output  4  hundreds digit, 0..2; constant 0 when WIDTH < 7.

Function
REQ-012 SHALL implement FSM states IDLE, CONV, DONE.
- IDLE -> CONV when start = 1.
- CONV -> DONE after exactly WIDTH cycles in CONV.
- DONE -> IDLE unconditionally after one cycle.
REQ-013 SHALL capture code_in on the start edge, converted to binary when mode = 1: bit i = XOR of code_in[WIDTH-1:i].
REQ-014 SHALL perform one double-dabble step per CONV cycle: any BCD nibble >= 5 gets +3, then a left shift of the {bcd, binary} register by one bit.
REQ-015 SHALL register the result into bcd_units/tens/hundreds on the CONV->DONE edge and assert valid for exactly the DONE cycle.
REQ-016 SHALL give a latency from the start-sampling edge to valid high of WIDTH+1 cycles.
REQ-017 SHALL hold the digit outputs at the last result until the next DONE; they SHALL never show intermediate shift values.
REQ-018 SHALL ignore start while busy = 1, including during the DONE cycle; a new start is accepted no earlier than the first IDLE cycle after valid.
REQ-019 SHALL handle boundary values: maximum input 2^WIDTH-1 yields the correct decimal digits; input 0 yields all digits 0.
REQ-020 SHALL ignore changes on code_in and mode after capture.

Reset
REQ-021 SHALL, on rst_n low, immediately force state IDLE, busy 0, valid 0, all digits 0, and the working register 0, regardless of clk.
REQ-022 SHALL abort an in-flight conversion when reset is asserted mid-operation; no valid pulse follows reset release.
REQ-023 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-024 SHALL place the FSM state enum and the constant BCD_ADJ = 4'd3 in shared package gray_bcd_pkg.
REQ-025 SHALL isolate the per-step nibble adjust (+3 if >= 5) in sub-module bcd_adjust_nibble, instantiated once per BCD digit.
REQ-026 SHALL feed bcd_units and bcd_tens directly to the downstream digit-multiplex stage's 4-bit digit input; the unused display positions stay blanked downstream.

Verification (WIDTH = 4 unless stated)
REQ-027 Gray case: mode = 1, code_in = 4'b1000, start pulse -> valid on the 5th edge after the start edge, tens = 1, units = 5.
REQ-028 Binary case: mode = 0, code_in = 4'b1001 -> tens = 0, units = 9; then code_in = 0 -> tens = 0, units = 0.
REQ-029 Busy lockout: start held high continuously with code 4'b0011 -> one valid per WIDTH+2 cycles; a code_in change during CONV does not alter the result.
REQ-030 Reset mid-operation: rst_n pulsed low in the 2nd CONV cycle -> busy and digits are 0 at once, and no valid pulse occurs afterwards without a new start.
REQ-031 WIDTH = 8, mode = 0, code_in = 8'd255 -> hundreds = 2, tens = 5, units = 5, valid on the 9th edge after the start edge.
REQ-032 Exhaustive sweep over all 16 codes in both modes -> digits match the decimal reference model every time, and valid is high exactly once per conversion.

Source files
------------

// File: rtl/gray_bcd_pkg.sv
// Shared types and constants for the Gray/binary to BCD converter.
// Holds the FSM state encoding and the double-dabble adjust constant.
package gray_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_ADJ = 4'd3;

endpackage

// File: rtl/gray_bcd_converter_adjust.sv
// One double-dabble nibble correction: add 3 when the digit is 5 or more,
// so the following left shift carries correctly into the next digit.
module bcd_adjust_nibble
    import gray_bcd_pkg::*;
(
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);

    always_comb begin
        nib_out = nib_in;
        if (nib_in >= 4'd5) begin
            nib_out = nib_in + BCD_ADJ;
        end
    end

endmodule

// File: rtl/gray_bcd_converter.sv
// Sequential Gray/binary to BCD converter using one double-dabble step
// per clock; the digit outputs only change when a conversion completes.
module gray_bcd_converter
    import gray_bcd_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] code_in,
    output logic             busy,
    output logic             valid,
    output logic [3:0]       bcd_units,
    output logic [3:0]       bcd_tens,
    output logic [3:0]       bcd_hundreds
);

    localparam int REG_W = 12 + WIDTH;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [REG_W-1:0] work_q, work_d;
    logic [3:0]       units_q, units_d;
    logic [3:0]       tens_q, tens_d;
    logic [3:0]       hund_q, hund_d;

    logic [WIDTH-1:0] gray_bin;
    logic [WIDTH-1:0] bin_in;
    logic             acc;
    logic [11:0]      bcd_adj;
    logic [REG_W-1:0] shifted;

    // Gray decode: each binary bit is the running XOR from the MSB down.
    always_comb begin
        acc      = 1'b0;
        gray_bin = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            acc         = acc ^ code_in[i];
            gray_bin[i] = acc;
        end
        bin_in = mode ? gray_bin : code_in;
    end

    for (genvar g = 0; g < 3; g++) begin : g_adj
        bcd_adjust_nibble u_adj (
            .nib_in  (work_q[WIDTH+4*g +: 4]),
            .nib_out (bcd_adj[4*g +: 4])
        );
    end

    assign shifted = {bcd_adj, work_q[WIDTH-1:0]} << 1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        work_d  = work_q;
        units_d = units_q;
        tens_d  = tens_q;
        hund_d  = hund_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CONV;
                    cnt_d   = 4'd0;
                    work_d  = {12'd0, bin_in};
                end
            end
            CONV: begin
                work_d = shifted;
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'(WIDTH - 1)) begin
                    state_d = DONE;
                    units_d = shifted[WIDTH +: 4];
                    tens_d  = shifted[WIDTH+4 +: 4];
                    hund_d  = (WIDTH >= 7) ? shifted[WIDTH+8 +: 4] : 4'd0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            work_q  <= '0;
            units_q <= 4'd0;
            tens_q  <= 4'd0;
            hund_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            work_q  <= work_d;
            units_q <= units_d;
            tens_q  <= tens_d;
            hund_q  <= hund_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign valid        = (state_q == DONE);
    assign bcd_units    = units_q;
    assign bcd_tens     = tens_q;
    assign bcd_hundreds = hund_q;

endmodule
